bicubic_window_fetch: RTL and testbench

BICUBIC_WINDOW_FETCH -- requirements
Module: bicubic_window_fetch

---
 rtl/bicubic_window_fetch_pkg.sv | 19 +
 rtl/bicubic_window_fetch_if.sv | 43 ++++
 rtl/bicubic_window_fetch_line_ram.sv | 36 +++
 rtl/bicubic_window_fetch.sv | 132 +++++++++++++
 tb/tb_bicubic_window_fetch.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/bicubic_window_fetch_pkg.sv
// ---------------------------------------------------------------------------
// bicubic_window_fetch_pkg
//   Shared defaults for the bicubic window fetch slice: pixel width and
//   image geometry, plus the window dimension used by the fetch logic.
//   No ports; imported by the interface, the top and the line RAM.
// ---------------------------------------------------------------------------
package bicubic_window_fetch_pkg;

  // Bits per pixel channel.
  localparam int BICUBIC_CHANNEL_WIDTH = 8;

  // Default input frame geometry in pixels and lines.
  localparam int BICUBIC_IMG_WIDTH  = 960;
  localparam int BICUBIC_IMG_HEIGHT = 540;

  // The bicubic kernel needs a 4x4 neighbourhood.
  localparam int BICUBIC_WIN = 4;

endpackage

// File: rtl/bicubic_window_fetch_if.sv
// ---------------------------------------------------------------------------
// bicubic_window_fetch_if
//   Bundles the pixel input stream, the 4x4 window request towards the
//   bicubic upsampler and the end-of-frame pulse.
//   slave  : seen by the window fetch block
//            (in: in_valid, in_data, bcci_req_ready;
//             out: in_ready, bf_req_valid, p1..p16, frame_done)
//   master : seen by the environment (pixel source and upsampler)
// ---------------------------------------------------------------------------
interface bicubic_window_fetch_if
  import bicubic_window_fetch_pkg::*;
#(
  parameter int CHANNEL_WIDTH = BICUBIC_CHANNEL_WIDTH
);

  logic                     in_valid;
  logic                     in_ready;
  logic [CHANNEL_WIDTH-1:0] in_data;
  logic                     bf_req_valid;
  logic                     bcci_req_ready;
  logic                     frame_done;

  // Window pixels, p(4r+c+1) = row r (0 = oldest line), column c (0 = left).
  logic [CHANNEL_WIDTH-1:0] p1,  p2,  p3,  p4;
  logic [CHANNEL_WIDTH-1:0] p5,  p6,  p7,  p8;
  logic [CHANNEL_WIDTH-1:0] p9,  p10, p11, p12;
  logic [CHANNEL_WIDTH-1:0] p13, p14, p15, p16;

  modport slave (
    input  in_valid, in_data, bcci_req_ready,
    output in_ready, bf_req_valid, frame_done,
    output p1, p2, p3, p4, p5, p6, p7, p8,
    output p9, p10, p11, p12, p13, p14, p15, p16
  );

  modport master (
    output in_valid, in_data, bcci_req_ready,
    input  in_ready, bf_req_valid, frame_done,
    input  p1, p2, p3, p4, p5, p6, p7, p8,
    input  p9, p10, p11, p12, p13, p14, p15, p16
  );

endinterface

// File: rtl/bicubic_window_fetch_line_ram.sv
// ---------------------------------------------------------------------------
// bicubic_line_ram
//   One line of pixels. Combinational read and synchronous write at the
//   same address, so a read in the writing cycle returns the old content.
//   Contents are not reset.
//   clk     : clock
//   we_i    : write enable
//   addr_i  : shared read/write address (pixel column)
//   wdata_i : data written on the rising edge when we_i is high
//   rdata_o : current content at addr_i
// ---------------------------------------------------------------------------
module bicubic_line_ram
  import bicubic_window_fetch_pkg::*;
#(
  parameter int DATA_W = BICUBIC_CHANNEL_WIDTH,
  parameter int DEPTH  = BICUBIC_IMG_WIDTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bicubic_window_fetch.sv
// ---------------------------------------------------------------------------
// bicubic_window_fetch
//   Turns a raster pixel stream into 4x4 windows for the bicubic upsampler.
//   Three line RAMs hold the previous three lines; each accepted pixel pushes
//   one new column into a 4x4 window register. A window is offered once the
//   current pixel is at least three lines down and three columns in.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : pixel stream, window handshake, p1..p16, frame_done
// ---------------------------------------------------------------------------
module bicubic_window_fetch
  import bicubic_window_fetch_pkg::*;
#(
  parameter int CHANNEL_WIDTH = BICUBIC_CHANNEL_WIDTH,
  parameter int IMG_WIDTH     = BICUBIC_IMG_WIDTH,
  parameter int IMG_HEIGHT    = BICUBIC_IMG_HEIGHT
) (
  input logic                  clk,
  input logic                  rst_n,
  bicubic_window_fetch_if.slave bus
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(BICUBIC_WIN - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(BICUBIC_WIN - 1);

  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic                     bfv_q, bfv_d;
  logic                     fd_q, fd_d;
  logic [CHANNEL_WIDTH-1:0] win_q [BICUBIC_WIN][BICUBIC_WIN];
  logic [CHANNEL_WIDTH-1:0] win_d [BICUBIC_WIN][BICUBIC_WIN];
  logic [CHANNEL_WIDTH-1:0] l0_rd, l1_rd, l2_rd;
  logic                     accept;

  // A held window blocks new pixels, since the next accept would overwrite it.
  assign bus.in_ready = !bfv_q || bus.bcci_req_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // The three RAMs form a column-wise shift chain: each line moves one
  // RAM older on every accept, and the incoming pixel enters L2.
  bicubic_line_ram #(.DATA_W(CHANNEL_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_l0 (
    .clk(clk), .we_i(accept), .addr_i(col_q), .wdata_i(l1_rd), .rdata_o(l0_rd)
  );
  bicubic_line_ram #(.DATA_W(CHANNEL_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_l1 (
    .clk(clk), .we_i(accept), .addr_i(col_q), .wdata_i(l2_rd), .rdata_o(l1_rd)
  );
  bicubic_line_ram #(.DATA_W(CHANNEL_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_l2 (
    .clk(clk), .we_i(accept), .addr_i(col_q), .wdata_i(bus.in_data), .rdata_o(l2_rd)
  );

  // Next-state: raster position, window shift, window-valid and frame pulse.
  // An accept always decides window-valid from the pixel just taken, which
  // also covers a window handshake landing in the same cycle.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    bfv_d = bfv_q;
    fd_d  = 1'b0;
    win_d = win_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          fd_d  = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
      for (int r = 0; r < BICUBIC_WIN; r++) begin
        for (int c = 0; c < BICUBIC_WIN - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      win_d[0][3] = l0_rd;
      win_d[1][3] = l1_rd;
      win_d[2][3] = l2_rd;
      win_d[3][3] = bus.in_data;
      bfv_d = (row_q >= ROW_MIN) && (col_q >= COL_MIN);
    end else if (bus.bcci_req_ready) begin
      bfv_d = 1'b0;
    end
  end

  // State registers; reset drops any pending window and restarts at (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      bfv_q <= 1'b0;
      fd_q  <= 1'b0;
      for (int r = 0; r < BICUBIC_WIN; r++) begin
        for (int c = 0; c < BICUBIC_WIN; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      bfv_q <= bfv_d;
      fd_q  <= fd_d;
      win_q <= win_d;
    end
  end

  assign bus.bf_req_valid = bfv_q;
  assign bus.frame_done   = fd_q;

  assign bus.p1  = win_q[0][0];
  assign bus.p2  = win_q[0][1];
  assign bus.p3  = win_q[0][2];
  assign bus.p4  = win_q[0][3];
  assign bus.p5  = win_q[1][0];
  assign bus.p6  = win_q[1][1];
  assign bus.p7  = win_q[1][2];
  assign bus.p8  = win_q[1][3];
  assign bus.p9  = win_q[2][0];
  assign bus.p10 = win_q[2][1];
  assign bus.p11 = win_q[2][2];
  assign bus.p12 = win_q[2][3];
  assign bus.p13 = win_q[3][0];
  assign bus.p14 = win_q[3][1];
  assign bus.p15 = win_q[3][2];
  assign bus.p16 = win_q[3][3];

endmodule

// File: tb/tb_bicubic_window_fetch.sv
// ---------------------------------------------------------------------------
// tb_bicubic_window_fetch
//   Bench for bicubic_window_fetch on an 8x6 image, pixel = row*16+col.
// ---------------------------------------------------------------------------
module tb_bicubic_window_fetch;

  localparam int CW = 8;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NWIN = (W - 3) * (H - 3);

  typedef struct {
    int       row;
    int       col;
    logic [7:0] p1;
    logic [7:0] p16;
  } windowVec_t;

  logic clk;
  logic rst_n;
  bicubic_window_fetch_if #(.CHANNEL_WIDTH(CW)) bus ();

  bicubic_window_fetch #(.CHANNEL_WIDTH(CW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  logic [7:0] pOut [16];
  assign pOut[0]  = bus.p1;
  assign pOut[1]  = bus.p2;
  assign pOut[2]  = bus.p3;
  assign pOut[3]  = bus.p4;
  assign pOut[4]  = bus.p5;
  assign pOut[5]  = bus.p6;
  assign pOut[6]  = bus.p7;
  assign pOut[7]  = bus.p8;
  assign pOut[8]  = bus.p9;
  assign pOut[9]  = bus.p10;
  assign pOut[10] = bus.p11;
  assign pOut[11] = bus.p12;
  assign pOut[12] = bus.p13;
  assign pOut[13] = bus.p14;
  assign pOut[14] = bus.p15;
  assign pOut[15] = bus.p16;

  windowVec_t windowTable [NWIN];
  int passCount = 0;
  int checkCount = 0;
  int fdCount = 0;
  int winCount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fdCount++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  // Presents pixel (r,c), optionally after a few idle cycles, and returns
  // #1 after the edge that accepts it.
  task automatic applyStimulus(input int r, input int c, input bit gaps);
    if (gaps) begin
      for (int k = 0; k < 3 && $urandom_range(0, 1) == 0; k++) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(r * 16 + c);
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.bcci_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkWindow16(input int r, input int c);
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (pOut[4*i+j] !== 8'((r - 3 + i) * 16 + (c - 3 + j))) bad++;
      end
    end
    checkOutput($sformatf("window16_bad_pixels@(%0d,%0d)", r, c), bad, 0);
  endtask

  task automatic streamFrame(input bit gaps);
    int wIdx = 0;
    bit expV;
    fdCount = 0;
    winCount = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        applyStimulus(r, c, gaps);
        expV = (wIdx < NWIN) && (windowTable[wIdx].row == r) && (windowTable[wIdx].col == c);
        checkOutput($sformatf("bf_req_valid@(%0d,%0d)", r, c), {31'b0, bus.bf_req_valid}, {31'b0, expV});
        checkOutput($sformatf("frame_done@(%0d,%0d)", r, c), {31'b0, bus.frame_done},
                    {31'b0, (r == H - 1) && (c == W - 1)});
        if (bus.bf_req_valid === 1'b1) winCount++;
        if (expV) begin
          checkOutput($sformatf("p1@(%0d,%0d)", r, c), bus.p1, windowTable[wIdx].p1);
          checkOutput($sformatf("p16@(%0d,%0d)", r, c), bus.p16, windowTable[wIdx].p16);
          checkWindow16(r, c);
          wIdx++;
        end
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("window_count", winCount, NWIN);
    checkOutput("frame_done_pulses", fdCount, 1);
  endtask

  initial begin
    int nz;
    windowTable[0]  = '{3, 3, 8'h00, 8'h33};
    windowTable[1]  = '{3, 4, 8'h01, 8'h34};
    windowTable[2]  = '{3, 5, 8'h02, 8'h35};
    windowTable[3]  = '{3, 6, 8'h03, 8'h36};
    windowTable[4]  = '{3, 7, 8'h04, 8'h37};
    windowTable[5]  = '{4, 3, 8'h10, 8'h43};
    windowTable[6]  = '{4, 4, 8'h11, 8'h44};
    windowTable[7]  = '{4, 5, 8'h12, 8'h45};
    windowTable[8]  = '{4, 6, 8'h13, 8'h46};
    windowTable[9]  = '{4, 7, 8'h14, 8'h47};
    windowTable[10] = '{5, 3, 8'h20, 8'h53};
    windowTable[11] = '{5, 4, 8'h21, 8'h54};
    windowTable[12] = '{5, 5, 8'h22, 8'h55};
    windowTable[13] = '{5, 6, 8'h23, 8'h56};
    windowTable[14] = '{5, 7, 8'h24, 8'h57};

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.bcci_req_ready = 1'b1;
    #1;
    checkOutput("reset_bf_req_valid", {31'b0, bus.bf_req_valid}, 0);
    checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 1);
    checkOutput("reset_frame_done", {31'b0, bus.frame_done}, 0);
    checkOutput("reset_p16", bus.p16, 0);
    resetDut();

    $display("[TB] full frame, continuous input");
    streamFrame(1'b0);
    $display("[TB] full frame, random input gaps");
    streamFrame(1'b1);

    $display("[TB] downstream stall");
    resetDut();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 3 || c <= 3) applyStimulus(r, c, 1'b0);
      end
    end
    checkOutput("stall_start_valid", {31'b0, bus.bf_req_valid}, 1);
    bus.bcci_req_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h34;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall_in_ready[%0d]", k), {31'b0, bus.in_ready}, 0);
      checkOutput($sformatf("stall_valid[%0d]", k), {31'b0, bus.bf_req_valid}, 1);
      checkOutput($sformatf("stall_p1[%0d]", k), bus.p1, 8'h00);
      checkOutput($sformatf("stall_p16[%0d]", k), bus.p16, 8'h33);
    end
    bus.bcci_req_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", {31'b0, bus.in_ready}, 1);
    @(posedge clk);
    #1;
    checkOutput("release_valid", {31'b0, bus.bf_req_valid}, 1);
    checkOutput("release_p1", bus.p1, 8'h01);
    checkOutput("release_p16", bus.p16, 8'h34);
    bus.in_valid = 1'b0;

    $display("[TB] reset mid-frame");
    resetDut();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r < 2 || c < 5) applyStimulus(r, c, 1'b0);
      end
    end
    bus.in_data = 8'h25;
    rst_n = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 16; i++) if (pOut[i] !== 8'h00) nz++;
    checkOutput("midreset_nonzero_pixels", nz, 0);
    checkOutput("midreset_bf_req_valid", {31'b0, bus.bf_req_valid}, 0);
    checkOutput("midreset_in_ready", {31'b0, bus.in_ready}, 1);
    checkOutput("midreset_frame_done", {31'b0, bus.frame_done}, 0);
    resetDut();
    streamFrame(1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
